axis_check_sink: RTL
====================

# axis_check_sink

AXI-Stream sink that terminates the output of the stream test source in the stream-based simulation bench. It drives `S_AXIS_TREADY`, optionally with pseudo-random backpressure, and checks that the received data is the incrementing sequence 0, 1, 2, … It also checks AXI-Stream hold rules and reports pass/fail once `COUNT` beats have been accepted.

## Interface
- `DATA_WIDTH`, 8: width of `TDATA`.
- `COUNT`, 32: beats accepted per run; must be ≥ 1.
- `STALL_EN`, 1: 1 = `TREADY` gated by LFSR; 0 = `TREADY` high throughout RUN.
- `LFSR_SEED`, 8'hA5: LFSR load value on start; must be nonzero.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  run request; honoured only in IDLE.
- `done`  out  1  one-cycle pulse after the final handshake.
- `pass`  out  1  result of the last completed run; held until the next start.
- `err_count`  out  16  data mismatches, saturating at 16'hFFFF.
- `first_err_idx`  out  IDX_W  beat index of the first mismatch; all-ones means none. IDX_W = $clog2(COUNT+1).
- `rx_count`  out  IDX_W  beats accepted in the current run.
- `protocol_err`  out  1  sticky hold-rule violation flag.
- `S_AXIS_TVALID`  in  1  upstream valid.
- `S_AXIS_TDATA`  in  DATA_WIDTH  upstream data.
- `S_AXIS_TREADY`  out  1  sink ready.

## Operation
- **States:** IDLE, RUN.
- **Reset** (`rst`=1 at an edge), from any state including mid-RUN:
  - state = IDLE; `done`, `pass`, `err_count`, `rx_count`, `protocol_err` = 0.
  - `first_err_idx` = all-ones; `expected` = 0; `lfsr` = `LFSR_SEED`.
- **IDLE → RUN:** when `start`=1. At the same edge, clear `err_count`, `rx_count`, `protocol_err`, `pass` and `expected`; set `first_err_idx` to all-ones; load `lfsr` with `LFSR_SEED`.
- **`start` in RUN:** ignored, with no effect on any state.
- **`TREADY`:** combinational, = (state==RUN) && (!`STALL_EN` || `lfsr[0]`).
- **LFSR:** in RUN it advances every cycle as `lfsr` <= {`lfsr[6:0]`, `lfsr[7]`^`lfsr[5]`^`lfsr[4]`^`lfsr[3]`}. It holds its value in IDLE.
- **Handshake** (`TVALID`&&`TREADY`):
  - Compare `TDATA` with `expected`.
  - On mismatch: `err_count`++ (saturating). If `first_err_idx` is all-ones, capture `rx_count` into it.
  - Always: `expected` <= `expected`+1 (wraps mod 2^DATA_WIDTH); `rx_count`++.
- **Completion:** a handshake with `rx_count`==COUNT−1 moves the state to IDLE. At that edge:
  - `done` <= 1;
  - `pass` <= (no mismatch so far, including this beat) && !`protocol_err` && (this cycle raises no violation).
- **Hold rule:** if `TVALID`=1 and `TREADY`=0 in cycle n (RUN only), then in cycle n+1 `TVALID` must be 1 and `TDATA` must be unchanged. Otherwise set `protocol_err`; it stays set until the next start or reset.
- **Legal bubbles:** `TVALID` low with no pending stall is legal and unchecked.
- **Outside RUN:** `TVALID` is ignored, with no check and no count.

## Timing
- `TREADY` can first be high in the cycle after the edge that sampled `start`.
- **Handshake effects:** counters, `expected` and error outputs update at the edge that ends the handshake cycle. There is zero added latency to acceptance.
- **End of run:** `done` is high for exactly the cycle after the final handshake edge. `pass` is valid from that same edge.
- **Restart:** `start` may be high in that `done` cycle (state is IDLE) and is honoured.
- **Back-to-back beats:** with `STALL_EN`=0, full throughput is one beat per cycle. COUNT beats take exactly COUNT cycles when `TVALID` is constantly high.
- **Stall check pipeline:** one register for the previous cycle's valid-and-not-ready status, and one register for the previous `TDATA`.
- **Reset priority:** reset overrides `start` and any handshake in the same cycle.

## Test plan
- **Always ready:** `STALL_EN`=0; drive 0..31 with `TVALID` held high → 32 handshakes in 32 consecutive cycles, `done` pulse, `pass`=1, `err_count`=0, `first_err_idx`=all-ones.
- **LFSR backpressure:** `STALL_EN`=1, seed A5; source with bubbles after each beat → `TREADY` matches the reference LFSR bit 0 every RUN cycle, all 32 accepted, `pass`=1, `protocol_err`=0.
- **Data mismatch:** corrupt beat 5 to 8'h55 and beat 9 to 8'h00 → `err_count`=2, `first_err_idx`=5, `pass`=0, `rx_count` reaches 32.
- **Hold-rule violation:** during a `TREADY`-low cycle with `TVALID`=1, change `TDATA` next cycle (same value sequence otherwise) → `protocol_err`=1 from the following edge, `pass`=0 at `done`, `err_count` reflects data check only.
- **Mid-run reset:** assert `rst` after 10 beats → the next cycle shows `TREADY`=0, `rx_count`=0, `err_count`=0 and `first_err_idx`=all-ones. A new `start` completes a clean 32-beat run with `pass`=1.
- **Start edge cases:** pulse `start` during RUN → no change to counters. Assert `start` in the `done` cycle → second run begins, `pass` cleared at that edge, second `done` after 32 more handshakes.

Source files
------------

// File: rtl/axis_check_sink_if.sv
// AXI-Stream link carrying the test source output into axis_check_sink.
interface axis_check_sink_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  TVALID;
  logic [DATA_WIDTH-1:0] TDATA;
  logic                  TREADY;

  modport master (output TVALID, output TDATA, input TREADY);
  modport slave  (input TVALID, input TDATA, output TREADY);
endinterface

// File: rtl/axis_check_sink.sv
// AXI-Stream sink: optional LFSR backpressure, checks an incrementing data
// sequence and the valid/data hold rule, reports pass/fail after COUNT beats.
module axis_check_sink #(
  parameter int         DATA_WIDTH = 8,
  parameter int         COUNT      = 32,
  parameter bit         STALL_EN   = 1'b1,
  parameter logic [7:0] LFSR_SEED  = 8'hA5,
  localparam int        IDX_W      = $clog2(COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [IDX_W-1:0] first_err_idx,
  output logic [IDX_W-1:0] rx_count,
  output logic             protocol_err,
  axis_check_sink_if.slave S_AXIS
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state;
  state_t                state_next;
  logic [7:0]            lfsr;
  logic [DATA_WIDTH-1:0] expected;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  stall_q;
  logic                  in_run;
  logic                  handshake;
  logic                  mismatch;
  logic                  last_beat;
  logic                  stall_now;
  logic                  violation;

  assign in_run        = (state == RUN);
  assign S_AXIS.TREADY = in_run && (!STALL_EN || lfsr[0]);
  assign handshake     = S_AXIS.TVALID && S_AXIS.TREADY;
  assign mismatch      = handshake && (S_AXIS.TDATA != expected);
  assign last_beat     = handshake && (rx_count == IDX_W'(COUNT - 1));
  assign stall_now     = in_run && S_AXIS.TVALID && !S_AXIS.TREADY;
  // A stalled beat must stay valid with identical data on the next cycle.
  assign violation     = in_run && stall_q &&
                         (!S_AXIS.TVALID || (S_AXIS.TDATA != data_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)     state_next = RUN;
      RUN:     if (last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '1;
      rx_count      <= '0;
      protocol_err  <= 1'b0;
      expected      <= '0;
      lfsr          <= LFSR_SEED;
      stall_q       <= 1'b0;
      data_q        <= '0;
    end else begin
      done    <= 1'b0;
      stall_q <= stall_now;
      data_q  <= S_AXIS.TDATA;
      if (!in_run) begin
        if (start) begin
          pass          <= 1'b0;
          err_count     <= '0;
          first_err_idx <= '1;
          rx_count      <= '0;
          protocol_err  <= 1'b0;
          expected      <= '0;
          lfsr          <= LFSR_SEED;
        end
      end else begin
        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        if (violation) begin
          protocol_err <= 1'b1;
        end
        if (handshake) begin
          if (mismatch) begin
            if (err_count != 16'hFFFF) begin
              err_count <= err_count + 16'd1;
            end
            if (first_err_idx == '1) begin
              first_err_idx <= rx_count;
            end
          end
          expected <= expected + DATA_WIDTH'(1);
          rx_count <= rx_count + IDX_W'(1);
          // Final beat: verdict covers this beat's data and this cycle's hold check.
          if (last_beat) begin
            done <= 1'b1;
            pass <= (err_count == 16'd0) && !mismatch && !protocol_err && !violation;
          end
        end
      end
    end
  end

endmodule
